// File: rtl/primogen_arbiter_pkg.sv
// rtl/primogen_arbiter_pkg.sv - shared FSM state encoding and helpers for the primogen arbiter
package primogen_arbiter_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_DELIVER = 3'd3,
      S_ACK_ERR = 3'd4
   } state_t;

   // Index width for a requester vector, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/primogen_arbiter_rr_pick.sv
// rtl/primogen_arbiter_rr_pick.sv - combinational round-robin picker: first set req after ptr, wrapping
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 valid,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   int            c;
   logic [IW-1:0] cand;

   // Scan from farthest to nearest so the nearest set request after ptr wins.
   always_comb begin
      valid = 1'b0;
      idx   = ptr;
      c     = 0;
      cand  = '0;
      for (int i = N; i >= 1; i--) begin
         c = int'(ptr) + i;
         if (c >= N) c = c - N;
         cand = c[IW-1:0];
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/primogen_arbiter.sv
// rtl/primogen_arbiter.sv - round-robin sharing of one primogen generator among NREQ clients
// Optional watchdog on generator calls: PRIMOGEN_ARB_TIMEOUT_EN.
module primogen_arbiter
   import primogen_arbiter_pkg::*;
#(
   parameter int WIDTH_LOG      = 4,
   parameter int NREQ           = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   output logic [NREQ-1:0]           ack,
   output logic [(1<<WIDTH_LOG)-1:0] data,
   output logic                      err,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic                      busy,
   output logic                      fault,
   output logic                      pg_go,
   input  logic                      pg_ready,
   input  logic                      pg_error,
   input  logic [(1<<WIDTH_LOG)-1:0] pg_res
);

   localparam int WIDTH = 1 << WIDTH_LOG;
   localparam int IW    = $clog2(NREQ);

   state_t        state, state_nx;
   logic [IW-1:0] ptr;
   logic          pick_valid;
   logic [IW-1:0] pick_idx;
   logic          tmo;

   rr_pick #(.N(NREQ)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

`ifdef PRIMOGEN_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (rst)                  tmo_cnt <= '0;
      else if (state == S_ISSUE) tmo_cnt <= '0;
      else if (state == S_WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo = (state == S_WAIT) && !pg_ready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      pg_go    = 1'b0;
      ack      = '0;
      case (state)
         S_IDLE:    if (pick_valid) state_nx = fault ? S_ACK_ERR : S_ISSUE;
         S_ISSUE: begin
            pg_go = pg_ready && !fault;
            if (pg_ready) state_nx = S_WAIT;
         end
         S_WAIT:    if (pg_ready || tmo) state_nx = S_DELIVER;
         S_DELIVER: begin
            ack[grant_id] = 1'b1;
            state_nx      = S_IDLE;
         end
         S_ACK_ERR: begin
            ack[grant_id] = 1'b1;
            state_nx      = S_IDLE;
         end
         default:   state_nx = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ptr      <= IW'(NREQ - 1);
         grant_id <= '0;
         data     <= '0;
         err      <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: if (pick_valid) begin
               grant_id <= pick_idx;
               if (fault) begin
                  data <= '0;
                  err  <= 1'b1;
               end
            end
            S_WAIT: if (pg_ready) begin
               data <= pg_res;
               err  <= pg_error;
               if (pg_error) fault <= 1'b1;
            end else if (tmo) begin
               data  <= WIDTH'(0);
               err   <= 1'b1;
               fault <= 1'b1;
            end
            S_DELIVER, S_ACK_ERR: ptr <= grant_id;
            default: ;
         endcase
      end
   end

   a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
   a_go_ready:   assert property (@(posedge clk) disable iff (rst) !(pg_go && !pg_ready));

endmodule
